// File: rtl/ds_sweep_ctrl_if.sv
// ============================================================================
// Module   : ds_sweep_ctrl_if
// Purpose  : Control/sample bundle between the register block and the sweep sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ds_sweep_ctrl_if #(
    parameter int FW = 28
);
    logic                 start;
    logic                 abort;
    logic [FW-1:0]        f_start;
    logic [FW-1:0]        f_stop;
    logic [FW-1:0]        f_step;
    logic [15:0]          dwell;
    logic signed [15:0]   din;
    logic                 cke;
    logic [FW-1:0]        freq;
    logic signed [15:0]   dout;
    logic [15:0]          gain;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output start, abort, f_start, f_stop, f_step, dwell, din,
        input  cke, freq, dout, gain, busy, done, err
    );

    modport slave (
        input  start, abort, f_start, f_stop, f_step, dwell, din,
        output cke, freq, dout, gain, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/ds_sweep_ctrl.sv
// ============================================================================
// Module   : ds_sweep_ctrl
// Purpose  : Modulator clock enable, linear NCO frequency sweep and pop-free gain envelope.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ds_sweep_ctrl #(
    parameter int          DIV_RATIO = 100,
    parameter int          FW        = 28,
    parameter logic [15:0] GAIN_STEP = 16'd64
) (
    input  logic           clk,
    input  logic           rst,
    ds_sweep_ctrl_if.slave bus
);

    localparam int              c_DIV_W    = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV_RATIO - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FADE_IN  = 3'd1,
        S_SWEEP    = 3'd2,
        S_FADE_OUT = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_DIV_W-1:0]   r_div;
    logic                 r_cke;
    logic [FW-1:0]        r_freq, w_freq_nxt;
    logic [15:0]          r_gain, w_gain_nxt;
    logic [15:0]          r_dcnt, w_dcnt_nxt;
    logic                 r_abort_lat, w_lat_nxt;
    logic                 r_err, w_err_nxt;
    logic                 w_load;
    logic [FW-1:0]        r_f_stop, r_f_step;
    logic [15:0]          r_dwell;
    logic signed [15:0]   r_dout;

    logic                 w_abort_any;
    logic [16:0]          w_gain_up;
    logic [15:0]          w_gain_up_sat, w_gain_dn_sat;
    logic [FW:0]          w_freq_sum;
    logic signed [31:0]   w_prod;

    assign w_abort_any   = r_abort_lat | bus.abort;
    assign w_gain_up     = {1'b0, r_gain} + {1'b0, GAIN_STEP};
    assign w_gain_up_sat = w_gain_up[16] ? 16'hFFFF : w_gain_up[15:0];
    assign w_gain_dn_sat = (r_gain > GAIN_STEP) ? (r_gain - GAIN_STEP) : 16'd0;
    // One extra bit so a step past the top of the word range cannot wrap below f_stop
    assign w_freq_sum    = {1'b0, r_freq} + {1'b0, r_f_step};
    assign w_prod        = bus.din * $signed({1'b0, r_gain});

    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq;
        w_gain_nxt  = r_gain;
        w_dcnt_nxt  = r_dcnt;
        w_lat_nxt   = r_abort_lat;
        w_err_nxt   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.f_start > bus.f_stop) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_FADE_IN;
                        w_freq_nxt  = bus.f_start;
                        w_gain_nxt  = 16'd0;
                        w_dcnt_nxt  = 16'd0;
                    end
                end
            end
            S_FADE_IN: begin
                if (bus.abort) w_lat_nxt = 1'b1;
                if (r_cke) begin
                    if (w_abort_any) begin
                        w_state_nxt = S_FADE_OUT;
                        w_lat_nxt   = 1'b0;
                    end else begin
                        w_gain_nxt = w_gain_up_sat;
                        if (w_gain_up_sat == 16'hFFFF) w_state_nxt = S_SWEEP;
                    end
                end
            end
            S_SWEEP: begin
                if (bus.abort) w_lat_nxt = 1'b1;
                if (r_cke) begin
                    // Abort outranks a coincident step boundary
                    if (w_abort_any) begin
                        w_state_nxt = S_FADE_OUT;
                        w_lat_nxt   = 1'b0;
                    end else if (r_dcnt == r_dwell - 16'd1) begin
                        w_dcnt_nxt = 16'd0;
                        if (w_freq_sum <= {1'b0, r_f_stop}) begin
                            w_freq_nxt = w_freq_sum[FW-1:0];
                        end else begin
                            w_state_nxt = S_FADE_OUT;
                            w_lat_nxt   = 1'b0;
                        end
                    end else begin
                        w_dcnt_nxt = r_dcnt + 16'd1;
                    end
                end
            end
            S_FADE_OUT: begin
                if (r_cke) begin
                    w_gain_nxt = w_gain_dn_sat;
                    if (w_gain_dn_sat == 16'd0) w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_cke       <= 1'b0;
            r_freq      <= '0;
            r_gain      <= 16'd0;
            r_dcnt      <= 16'd0;
            r_abort_lat <= 1'b0;
            r_err       <= 1'b0;
            r_f_stop    <= '0;
            r_f_step    <= '0;
            r_dwell     <= 16'd1;
            r_dout      <= 16'sd0;
        end else begin
            r_cke       <= (r_div == c_DIV_LAST);
            r_div       <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
            r_state     <= w_state_nxt;
            r_freq      <= w_freq_nxt;
            r_gain      <= w_gain_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_abort_lat <= w_lat_nxt;
            r_err       <= w_err_nxt;
            r_dout      <= 16'(w_prod >>> 16);
            if (w_load) begin
                r_f_stop <= bus.f_stop;
                r_f_step <= bus.f_step;
                r_dwell  <= (bus.dwell == 16'd0) ? 16'd1 : bus.dwell;
            end
        end
    end

    assign bus.cke  = r_cke;
    assign bus.freq = r_freq;
    assign bus.gain = r_gain;
    assign bus.dout = r_dout;
    assign bus.err  = r_err;
    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ds_sweep_ctrl.sv
// ============================================================================
// Module   : tb_ds_sweep_ctrl
// Purpose  : Scoreboard bench for ds_sweep_ctrl (DIV_RATIO=4, GAIN_STEP=16384).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ds_sweep_ctrl;

    localparam int FW = 28;

    typedef struct {
        logic [FW-1:0] freq;
        logic [15:0]   gain;
        int            ticks;   // ticks since previous change; -1 = not checked
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    logic mon_en;
    exp_t sb_q[$];
    logic signed [15:0] dq[$];

    ds_sweep_ctrl_if #(.FW(FW)) bus ();

    ds_sweep_ctrl #(
        .DIV_RATIO (4),
        .FW        (FW),
        .GAIN_STEP (16'd16384)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [FW-1:0] f, input logic [15:0] g, input int t);
        exp_t e;
        e.freq = f; e.gain = g; e.ticks = t;
        sb_q.push_back(e);
    endtask

    task automatic push_fade_in(input logic [FW-1:0] f);
        push(f, 16'd0, -1);
        push(f, 16'd16384, 1);
        push(f, 16'd32768, 1);
        push(f, 16'd49152, 1);
        push(f, 16'd65535, 1);
    endtask

    task automatic push_fade_out(input logic [FW-1:0] f, input int first_ticks);
        push(f, 16'd49151, first_ticks);
        push(f, 16'd32767, 1);
        push(f, 16'd16383, 1);
        push(f, 16'd0, 1);
    endtask

    task automatic start_pulse(input logic [FW-1:0] fs, input logic [FW-1:0] fe,
                               input logic [FW-1:0] st, input logic [15:0] dw);
        @(negedge clk);
        bus.f_start = fs; bus.f_stop = fe; bus.f_step = st; bus.dwell = dw;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic apply_din(input logic signed [15:0] d, input logic signed [15:0] exp);
        bus.din = d;
        dq.push_back(exp);
        @(negedge clk);
        chk("dout", 64'(bus.dout), 64'(dq.pop_front()));
    endtask

    task automatic wait_gain(input string tag, input logic [15:0] g);
        for (int i = 0; i < 1000 && bus.gain !== g; i++) @(negedge clk);
        chk(tag, bus.gain, g);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2000 && bus.done !== 1'b1; i++) @(negedge clk);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_busy_at_done"}, bus.busy, 1);
        @(negedge clk);
        chk({tag, "_done_1clk"}, bus.done, 0);
        chk({tag, "_busy_idle"}, bus.busy, 0);
        chk({tag, "_sb_drained"}, sb_q.size(), 0);
    endtask

    // Transaction monitor: each change of (freq, gain) pops one expected entry
    initial begin
        logic [FW-1:0] prev_freq;
        logic [15:0]   prev_gain;
        int            tick_cnt;
        exp_t          e;
        prev_freq = '0; prev_gain = '0; tick_cnt = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.freq !== prev_freq || bus.gain !== prev_gain) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_nonempty", sb_q.size(), 1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sb_freq", bus.freq, e.freq);
                        chk("sb_gain", bus.gain, e.gain);
                        if (e.ticks >= 0) chk("sb_ticks", tick_cnt, e.ticks);
                    end
                    prev_freq = bus.freq;
                    prev_gain = bus.gain;
                    tick_cnt  = 0;
                end
                if (bus.cke) tick_cnt++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; mon_en = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.f_start = '0; bus.f_stop = '0; bus.f_step = '0; bus.dwell = '0;
        bus.din = '0;
        repeat (3) @(negedge clk);
        chk("rst_cke",  bus.cke, 0);
        chk("rst_freq", bus.freq, 0);
        chk("rst_gain", bus.gain, 0);
        chk("rst_dout", 64'(bus.dout), 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err",  bus.err, 0);
        rst = 1'b0;

        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("cke_clk%0d", k), bus.cke, ((k % 4) == 0) ? 1 : 0);
        end
        mon_en = 1'b1;

        // Rejected start
        start_pulse(28'd500, 28'd400, 28'd1, 16'd1);
        chk("rej_err",  bus.err, 1);
        chk("rej_busy", bus.busy, 0);
        chk("rej_freq", bus.freq, 0);
        @(negedge clk);
        chk("rej_err_1clk", bus.err, 0);

        // Scaling with zero gain
        apply_din(16'sd20000, 16'sd0);
        apply_din(-16'sd32768, 16'sd0);
        bus.din = 16'sd0;

        // Full sweep 100..400 step 100, dwell 2
        push_fade_in(28'd100);
        push(28'd200, 16'd65535, 2);
        push(28'd300, 16'd65535, 2);
        push(28'd400, 16'd65535, 2);
        push_fade_out(28'd400, 3);
        start_pulse(28'd100, 28'd400, 28'd100, 16'd2);
        chk("sweep_busy", bus.busy, 1);
        wait_gain("sweep_g32k", 16'd32768);
        apply_din(-16'sd32768, -16'sd16384);
        apply_din(16'sd20000, 16'sd10000);
        apply_din(16'sd0, 16'sd0);
        wait_done("sweep");

        // Abort mid-sweep with f_step=0, plus an ignored start during fade-out
        push_fade_in(28'd1000);
        push_fade_out(28'd1000, -1);
        start_pulse(28'd1000, 28'd2000, 28'd0, 16'd3);
        wait_gain("abort_g_full", 16'd65535);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8 && bus.cke; i++) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_freq_held", bus.freq, 1000);
        wait_gain("abort_fading", 16'd49151);
        start_pulse(28'd5, 28'd10, 28'd1, 16'd1);
        chk("abort_restart_err", bus.err, 0);
        chk("abort_restart_freq", bus.freq, 1000);
        wait_done("abort");

        // Overflow-safe compare at the top of the word range
        push_fade_in(28'h800_0000);
        push_fade_out(28'h800_0000, 2);
        start_pulse(28'h800_0000, 28'hFFF_FFFF, 28'h800_0000, 16'd1);
        wait_done("ovf");

        // dwell=0 steps every tick
        push_fade_in(28'd10);
        push(28'd20, 16'd65535, 1);
        push(28'd30, 16'd65535, 1);
        push_fade_out(28'd30, 2);
        start_pulse(28'd10, 28'd30, 28'd10, 16'd0);
        wait_done("dwell0");

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
